// File: rtl/ant_group_buffer.sv
// ant_group_buffer: NGRP-way double-buffered antenna group buffer with RE-aligned parallel readout.
//   Inputs : i_clk, i_reset_n (async, active-low), i_iq_data/i_iq_vld/i_iq_last (one group after another)
//   Outputs: o_ant_data (all groups of one RE), o_ant_addr, o_tvalid, o_tlast,
//            o_overflow (sticky symbol drop), o_len_err (sticky bad group length)
//   Optional: define ANT_BUF_DROP_CNT_EN to add o_drop_cnt, a saturating count of dropped symbols.
module ant_group_buffer #(
  parameter int ANT          = 4,
  parameter int NGRP         = 4,
  parameter int RE_NUM       = 1584,
  parameter int ADDR_WIDTH   = 11,
  parameter int READ_LATENCY = 3
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  input  logic [ANT*32-1:0]         i_iq_data,
  input  logic                      i_iq_vld,
  input  logic                      i_iq_last,
  output logic [NGRP*ANT*32-1:0]    o_ant_data,
  output logic [ADDR_WIDTH-1:0]     o_ant_addr,
  output logic                      o_tvalid,
  output logic                      o_tlast,
  output logic                      o_overflow,
  output logic                      o_len_err
`ifdef ANT_BUF_DROP_CNT_EN
  ,output logic [15:0]              o_drop_cnt
`endif
);
  localparam int W = ANT * 32;
  localparam int GW = $clog2(NGRP);
  localparam logic [ADDR_WIDTH:0] RE_END = (ADDR_WIDTH+1)'(RE_NUM);
  localparam logic [ADDR_WIDTH-1:0] RE_LAST = ADDR_WIDTH'(RE_NUM - 1);
  localparam logic [GW-1:0] GRP_LAST = GW'(NGRP - 1);
  typedef enum logic {IDLE, RUN} state_t;
  // wr_re carries one extra bit so it can sit at RE_NUM while a long group's excess beats are discarded
  logic [ADDR_WIDTH:0]   wr_re_q, wr_re_d;
  logic [GW-1:0]         wr_grp_q, wr_grp_d;
  logic                  wr_page_q, wr_page_d;
  logic                  drop_q, drop_d;
  logic [1:0]            full_cnt_q, full_cnt_d;
  logic                  overflow_q, overflow_d;
  logic                  len_err_q, len_err_d;
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] rd_re_q, rd_re_d;
  logic                  rd_page_q, rd_page_d;
  logic                  sym_start, ovf_start, drop_now, wr_en, grp_end, sym_end, commit, rel, rd_issue;
  logic                  sel_q;
  logic [W-1:0]          bank_q [NGRP][2];
  logic [NGRP*W-1:0]     mux_data;
  logic [READ_LATENCY-1:0] v_q;
  logic [ADDR_WIDTH-1:0] a_q [READ_LATENCY];
  assign sym_start = i_iq_vld && wr_grp_q == '0 && wr_re_q == '0;
  // occupancy is judged on the registered count, so a release in this same cycle does not save the symbol
  assign ovf_start = sym_start && full_cnt_q == 2'd2;
  assign drop_now  = drop_q || ovf_start;
  assign wr_en     = i_iq_vld && !drop_now && wr_re_q < RE_END;
  assign grp_end   = i_iq_vld && i_iq_last;
  assign sym_end   = grp_end && wr_grp_q == GRP_LAST;
  assign commit    = sym_end && !drop_now;
  assign rd_issue  = state_q == RUN;
  assign rel       = rd_issue && rd_re_q == RE_LAST;
  always_comb begin
    wr_re_d    = grp_end ? '0 : (i_iq_vld && wr_re_q < RE_END) ? wr_re_q + 1'b1 : wr_re_q;
    wr_grp_d   = !grp_end ? wr_grp_q : (wr_grp_q == GRP_LAST) ? '0 : wr_grp_q + 1'b1;
    wr_page_d  = wr_page_q ^ commit;
    drop_d     = drop_now && !sym_end;
    full_cnt_d = full_cnt_q + {1'b0, commit} - {1'b0, rel};
    overflow_d = overflow_q || ovf_start;
    len_err_d  = len_err_q || (i_iq_vld && wr_re_q >= RE_END) || (grp_end && wr_re_q + 1'b1 != RE_END);
  end
  always_comb begin
    state_d   = state_q;
    rd_re_d   = rd_re_q;
    rd_page_d = rd_page_q;
    if (state_q == IDLE) begin
      state_d = (full_cnt_q != 2'd0) ? RUN : IDLE;
    end else if (rel) begin
      rd_re_d   = '0;
      rd_page_d = !rd_page_q;
      // a symbol committing in the release cycle is read back-to-back as well
      state_d   = (full_cnt_q > 2'd1 || commit) ? RUN : IDLE;
    end else begin
      rd_re_d = rd_re_q + 1'b1;
    end
  end
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_re_q    <= '0;
      wr_grp_q   <= '0;
      wr_page_q  <= 1'b0;
      drop_q     <= 1'b0;
      full_cnt_q <= '0;
      overflow_q <= 1'b0;
      len_err_q  <= 1'b0;
      state_q    <= IDLE;
      rd_re_q    <= '0;
      rd_page_q  <= 1'b0;
    end else begin
      wr_re_q    <= wr_re_d;
      wr_grp_q   <= wr_grp_d;
      wr_page_q  <= wr_page_d;
      drop_q     <= drop_d;
      full_cnt_q <= full_cnt_d;
      overflow_q <= overflow_d;
      len_err_q  <= len_err_d;
      state_q    <= state_d;
      rd_re_q    <= rd_re_d;
      rd_page_q  <= rd_page_d;
    end
  end
  for (genvar g = 0; g < NGRP; g++) begin : g_grp
    for (genvar p = 0; p < 2; p++) begin : g_page
      logic [W-1:0] mem [RE_NUM];
      logic [W-1:0] rd_q;
      always_ff @(posedge i_clk) begin
        if (wr_en && wr_grp_q == GW'(g) && wr_page_q == 1'(p)) mem[wr_re_q[ADDR_WIDTH-1:0]] <= i_iq_data;
      end
      always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) rd_q <= '0;
        else if (rd_issue && rd_page_q == 1'(p)) rd_q <= mem[rd_re_q];
      end
      assign bank_q[g][p] = rd_q;
    end
  end
  // page select follows the RAM output register so the mux holds with the banks between symbols
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) sel_q <= 1'b0;
    else if (rd_issue) sel_q <= rd_page_q;
  end
  always_comb begin
    mux_data = '0;
    for (int i = 0; i < NGRP; i++) mux_data[i*W +: W] = bank_q[i][sel_q];
  end
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      v_q <= '0;
      for (int k = 0; k < READ_LATENCY; k++) a_q[k] <= '0;
    end else begin
      v_q[0] <= rd_issue;
      a_q[0] <= rd_re_q;
      for (int k = 1; k < READ_LATENCY; k++) begin
        v_q[k] <= v_q[k-1];
        a_q[k] <= a_q[k-1];
      end
    end
  end
  if (READ_LATENCY == 1) begin : g_lat1
    assign o_ant_data = mux_data;
  end else begin : g_latn
    logic [NGRP*W-1:0] d_q [READ_LATENCY-1];
    always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
        for (int k = 0; k < READ_LATENCY-1; k++) d_q[k] <= '0;
      end else begin
        if (v_q[0]) d_q[0] <= mux_data;
        for (int k = 1; k < READ_LATENCY-1; k++) if (v_q[k]) d_q[k] <= d_q[k-1];
      end
    end
    assign o_ant_data = d_q[READ_LATENCY-2];
  end
  assign o_tvalid   = v_q[READ_LATENCY-1];
  assign o_ant_addr = a_q[READ_LATENCY-1];
  assign o_tlast    = o_tvalid && o_ant_addr == RE_LAST;
  assign o_overflow = overflow_q;
  assign o_len_err  = len_err_q;
`ifdef ANT_BUF_DROP_CNT_EN
  logic [15:0] drop_cnt_q;
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) drop_cnt_q <= '0;
    else if (ovf_start && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
  end
  assign o_drop_cnt = drop_cnt_q;
`endif
endmodule

// File: tb/tb_ant_group_buffer.sv
// tb_ant_group_buffer: randomized self-checking bench for ant_group_buffer against a timestamped symbol model.
module tb_ant_group_buffer;
  localparam int NG = 2, AN = 4, RN = 8, AW = 3, RL = 3, W = AN * 32;
  logic clk = 1'b0;
  logic i_reset_n = 1'b0;
  logic [W-1:0] i_iq_data = '0;
  logic i_iq_vld = 1'b0, i_iq_last = 1'b0;
  logic [NG*W-1:0] o_ant_data;
  logic [AW-1:0] o_ant_addr;
  logic o_tvalid, o_tlast, o_overflow, o_len_err;
`ifdef ANT_BUF_DROP_CNT_EN
  logic [15:0] o_drop_cnt;
`endif
  always #5 clk = ~clk;
  ant_group_buffer #(.ANT(AN), .NGRP(NG), .RE_NUM(RN), .ADDR_WIDTH(AW), .READ_LATENCY(RL)) dut (
    .i_clk(clk), .i_reset_n(i_reset_n), .i_iq_data(i_iq_data), .i_iq_vld(i_iq_vld), .i_iq_last(i_iq_last),
    .o_ant_data(o_ant_data), .o_ant_addr(o_ant_addr), .o_tvalid(o_tvalid), .o_tlast(o_tlast),
    .o_overflow(o_overflow), .o_len_err(o_len_err)
`ifdef ANT_BUF_DROP_CNT_EN
    , .o_drop_cnt(o_drop_cnt)
`endif
  );
  typedef struct {int t; int a; logic [NG*W-1:0] d; logic [NG*W-1:0] m;} beat_t;
  beat_t eq[$];
  int rel_q[$];
  int n_chk = 0, n_err = 0, cyc = 0;
  int m_grp, m_re, m_page, m_drops, last_rel;
  bit m_drop, m_ovf, m_len;
  logic [W-1:0] mm [NG][2][RN];
  bit mk [NG][2][RN];
  logic [NG*W-1:0] hold_d, hold_m;
  task automatic check(input string tag, input logic [NG*W-1:0] act, input logic [NG*W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, act, exp);
    end
  endtask
  task automatic model_reset();
    m_grp = 0; m_re = 0; m_page = 0; m_drop = 0; m_ovf = 0; m_len = 0; m_drops = 0;
    last_rel = -1000; rel_q.delete(); eq.delete();
    hold_d = '0; hold_m = '1;
  endtask
  function automatic int occupancy(input int t);
    while (rel_q.size() > 0 && rel_q[0] < t) void'(rel_q.pop_front());
    return rel_q.size();
  endfunction
  // a committed symbol is read right after the previous one when already pending at its release,
  // otherwise one idle cycle after the commit; each beat leaves RL edges after its read issue
  task automatic commit_sym(input int t);
    int r;
    beat_t b;
    r = (last_rel >= t) ? last_rel + RN : t + 1 + RN;
    last_rel = r;
    rel_q.push_back(r);
    for (int k = 0; k < RN; k++) begin
      b.t = r - RN + k + RL;
      b.a = k;
      for (int g = 0; g < NG; g++) begin
        b.d[g*W +: W] = mm[g][m_page][k];
        b.m[g*W +: W] = {W{mk[g][m_page][k]}};
      end
      eq.push_back(b);
    end
    m_page ^= 1;
  endtask
  task automatic model_beat(input int t, input bit l, input logic [W-1:0] d);
    if (m_grp == 0 && m_re == 0 && occupancy(t) == 2) begin
      m_drop = 1; m_ovf = 1; m_drops++;
    end
    if (m_re >= RN) m_len = 1;
    else if (!m_drop) begin
      mm[m_grp][m_page][m_re] = d;
      mk[m_grp][m_page][m_re] = 1;
    end
    if (l) begin
      if (m_re + 1 != RN) m_len = 1;
      m_re = 0;
      if (m_grp == NG - 1) begin
        m_grp = 0;
        if (m_drop) m_drop = 0;
        else commit_sym(t);
      end else m_grp++;
    end else m_re++;
  endtask
  task automatic check_out();
    beat_t e;
    if (eq.size() > 0 && eq[0].t == cyc) begin
      e = eq.pop_front();
      check("tvalid", o_tvalid, 1);
      check("addr", o_ant_addr, e.a);
      check("tlast", o_tlast, e.a == RN - 1);
      check("data", o_ant_data & e.m, e.d & e.m);
      hold_d = e.d; hold_m = e.m;
    end else begin
      check("tvalid_idle", o_tvalid, 0);
      check("tlast_idle", o_tlast, 0);
      check("data_hold", o_ant_data & hold_m, hold_d & hold_m);
    end
    check("overflow", o_overflow, m_ovf);
    check("len_err", o_len_err, m_len);
`ifdef ANT_BUF_DROP_CNT_EN
    check("drop_cnt", o_drop_cnt, m_drops);
`endif
  endtask
  task automatic step(input logic v, input logic l, input logic [W-1:0] d);
    i_iq_vld = v; i_iq_last = l; i_iq_data = d;
    if (v && i_reset_n) model_beat(cyc + 1, l, d);
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check_out();
  endtask
  task automatic idle(input int n);
    repeat (n) step(0, 0, '0);
  endtask
  task automatic send_grp(input int len, input int base, input int gap);
    logic [31:0] w;
    for (int n = 0; n < len; n++) begin
      if (gap > 0 && $urandom_range(99) < gap) step(0, 0, '0);
      w = 32'(base + n);
      step(1, n == len - 1, base >= 0 ? {AN{w}} : {$urandom(), $urandom(), $urandom(), $urandom()});
    end
  endtask
  task automatic do_reset();
    i_iq_vld = 0; i_iq_last = 0; i_reset_n = 0;
    #1;
    check("rst_data", o_ant_data, 0);
    check("rst_addr", o_ant_addr, 0);
    check("rst_tvalid", o_tvalid, 0);
    check("rst_tlast", o_tlast, 0);
    check("rst_overflow", o_overflow, 0);
    check("rst_len_err", o_len_err, 0);
    model_reset();
    idle(2);
    i_reset_n = 1;
  endtask
  initial begin
    model_reset();
    @(negedge clk);
    do_reset();
    send_grp(RN, 'h100, 0);
    send_grp(RN, 'h200, 0);
    idle(20);
    repeat (3) begin
      send_grp(RN, -1, 0);
      send_grp(RN, -1, 0);
    end
    idle(30);
    do_reset();
    repeat (3) begin
      send_grp(1, -1, 0);
      send_grp(1, -1, 0);
    end
    idle(40);
    send_grp(RN, -1, 0);
    send_grp(RN, -1, 0);
    idle(30);
    check("ovf_seen", o_overflow, 1);
    do_reset();
    send_grp(6, -1, 0);
    send_grp(RN, -1, 0);
    send_grp(RN, -1, 0);
    send_grp(RN, -1, 0);
    idle(30);
    do_reset();
    send_grp(10, -1, 0);
    send_grp(RN, -1, 0);
    send_grp(RN, -1, 0);
    send_grp(RN, -1, 0);
    idle(30);
    send_grp(RN, -1, 0);
    for (int n = 0; n < 4; n++) step(1, 0, {$urandom(), $urandom(), $urandom(), $urandom()});
    do_reset();
    send_grp(RN, 'h300, 0);
    send_grp(RN, 'h400, 0);
    idle(30);
    repeat (10) begin
      for (int g = 0; g < NG; g++) send_grp(($urandom_range(3) == 0) ? $urandom_range(10, 1) : RN, -1, 20);
    end
    idle(40);
    check("drain", eq.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
